// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: opcode width and encoding.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_NOT    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XOR    = 3'd5,
    OP_XNOR   = 3'd6,
    OP_PASS_A = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Upstream (op/a/b) and downstream (y/flags) valid/ready channels of the logic unit.
interface logic_unit_pipe_if #(parameter int WIDTH = 8);
  import logic_unit_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             ones;
  logic             parity;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, zero, ones, parity
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, zero, ones, parity
  );

endinterface

// File: rtl/logic_op_core.sv
// Combinational bitwise gate selected by op; no carries, result is exactly WIDTH bits.
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    // NOTE: y gets a value before the case so no path through this block can infer a latch.
    y = '0;
    case (op_e'(op))
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_NOT:    y = ~a;
      OP_NAND:   y = ~(a & b);
      OP_NOR:    y = ~(a | b);
      OP_XOR:    y = a ^ b;
      OP_XNOR:   y = ~(a ^ b);
      OP_PASS_A: y = a;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline around logic_op_core; stage 2 also registers the
// zero / all-ones / parity reduction flags of the result.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  logic_unit_pipe_if.slave   bus
);

  logic [WIDTH-1:0] f_y;
  logic [WIDTH-1:0] y1;
  logic             s1_valid;
  logic             s2_load;
  logic             in_fire;

  logic             out_valid_q;
  logic [WIDTH-1:0] y_q;
  logic             zero_q;
  logic             ones_q;
  logic             parity_q;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op (bus.op),
    .a  (bus.a),
    .b  (bus.b),
    .y  (f_y)
  );

  // s2 can take s1's word when it is empty or is being drained this cycle.
  assign s2_load = s1_valid & (~out_valid_q | bus.out_ready);
  assign bus.in_ready = ~s1_valid | s2_load;
  assign in_fire = bus.in_valid & bus.in_ready;

  // NOTE: pipeline state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      y1          <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b1;
      ones_q      <= 1'b0;
      parity_q    <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        y1       <= f_y;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        out_valid_q <= 1'b1;
        y_q         <= y1;
        zero_q      <= ~|y1;
        ones_q      <= &y1;
        parity_q    <= ^y1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
  assign bus.ones      = ones_q;
  assign bus.parity    = parity_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: op sweep table, stall, random stream, mid-stream reset,
// and WIDTH=1 / WIDTH=64 corner instances.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  typedef struct packed {
    logic [7:0] y;
    logic       zero;
    logic       ones;
    logic       parity;
  } out_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic_unit_pipe_if #(.WIDTH(8))  dut_if ();
  logic_unit_pipe_if #(.WIDTH(1))  w1_if ();
  logic_unit_pipe_if #(.WIDTH(64)) w64_if ();

  logic_unit_pipe #(.WIDTH(8))  dut   (.clk(clk), .rst(rst), .bus(dut_if));
  logic_unit_pipe #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(w1_if));
  logic_unit_pipe #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(w64_if));

  // Truth tables indexed by {a_bit, b_bit}.
  logic [3:0] truth [0:7] = '{4'b1000, 4'b1110, 4'b0011, 4'b0111,
                              4'b0001, 4'b0110, 4'b1001, 4'b1100};

  out_t exp_q[$];
  out_t got_q[$];
  logic mon_en = 1'b0;

  function automatic out_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    out_t       r;
    logic [3:0] tt;
    tt = truth[op];
    for (int i = 0; i < 8; i++) r.y[i] = tt[{a[i], b[i]}];
    r.zero   = (r.y == 8'h00);
    r.ones   = (r.y == 8'hFF);
    r.parity = ^r.y;
    return r;
  endfunction

  function automatic out_t dut_out();
    out_t r;
    r.y      = dut_if.y;
    r.zero   = dut_if.zero;
    r.ones   = dut_if.ones;
    r.parity = dut_if.parity;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (mon_en && dut_if.out_valid && dut_if.out_ready) got_q.push_back(dut_out());

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input bit rand_rdy);
    bit done = 0;
    dut_if.in_valid = 1'b1;
    dut_if.op = op;
    dut_if.a  = a;
    dut_if.b  = b;
    for (int k = 0; k < 200 && !done; k++) begin
      if (rand_rdy) dut_if.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (dut_if.in_ready) begin
        exp_q.push_back(model(op, a, b));
        done = 1;
      end
      next_cycle();
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
    dut_if.in_valid = 1'b0;
  endtask

  task automatic drain();
    dut_if.out_ready = 1'b1;
    for (int k = 0; k < 200 && got_q.size() < exp_q.size(); k++) next_cycle();
    next_cycle();
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{3'd0, 8'hC5, 8'h3A, '{8'h00, 1'b1, 1'b0, 1'b0}},
      '{3'd1, 8'hC5, 8'h3A, '{8'hFF, 1'b0, 1'b1, 1'b0}},
      '{3'd2, 8'hC5, 8'h3A, '{8'h3A, 1'b0, 1'b0, 1'b0}},
      '{3'd3, 8'hC5, 8'h3A, '{8'hFF, 1'b0, 1'b1, 1'b0}},
      '{3'd4, 8'hC5, 8'h3A, '{8'h00, 1'b1, 1'b0, 1'b0}},
      '{3'd5, 8'hC5, 8'h3A, '{8'hFF, 1'b0, 1'b1, 1'b0}},
      '{3'd6, 8'hC5, 8'h3A, '{8'h00, 1'b1, 1'b0, 1'b0}},
      '{3'd7, 8'hC5, 8'h3A, '{8'hC5, 1'b0, 1'b0, 1'b0}},
      '{3'd5, 8'h81, 8'h01, '{8'h80, 1'b0, 1'b0, 1'b1}},
      '{3'd1, 8'h07, 8'h03, '{8'h07, 1'b0, 1'b0, 1'b1}},
      '{3'd0, 8'h0F, 8'h0F, '{8'h0F, 1'b0, 1'b0, 1'b0}},
      '{3'd2, 8'hFE, 8'h55, '{8'h01, 1'b0, 1'b0, 1'b1}},
      '{3'd6, 8'h00, 8'h00, '{8'hFF, 1'b0, 1'b1, 1'b0}},
      '{3'd4, 8'hFF, 8'h00, '{8'h00, 1'b1, 1'b0, 1'b0}}
    };

    dut_if.in_valid = 1'b0; dut_if.op = '0; dut_if.a = '0; dut_if.b = '0; dut_if.out_ready = 1'b0;
    w1_if.in_valid  = 1'b0; w1_if.op  = '0; w1_if.a  = '0; w1_if.b  = '0; w1_if.out_ready  = 1'b1;
    w64_if.in_valid = 1'b0; w64_if.op = '0; w64_if.a = '0; w64_if.b = '0; w64_if.out_ready = 1'b1;

    // 1. Reset for two cycles.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(dut_if.out_valid), 64'd0);
    check("rst_flags", 64'(dut_out()), 64'({8'h00, 1'b1, 1'b0, 1'b0}));
    check("rst_in_ready", 64'(dut_if.in_ready), 64'd1);
    next_cycle();

    // 2. Back-to-back op sweep; each word shows two cycles after it is offered.
    dut_if.out_ready = 1'b1;
    for (int c = 0; c < vecs.size() + 2; c++) begin
      if (c < vecs.size()) begin
        dut_if.in_valid = 1'b1;
        dut_if.op = vecs[c].op;
        dut_if.a  = vecs[c].a;
        dut_if.b  = vecs[c].b;
      end else begin
        dut_if.in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < vecs.size()) check("sweep_in_ready", 64'(dut_if.in_ready), 64'd1);
      if (c >= 2) begin
        check($sformatf("sweep_valid_%0d", c - 2), 64'(dut_if.out_valid), 64'd1);
        check($sformatf("sweep_out_%0d", c - 2), 64'(dut_out()), 64'(vecs[c-2].exp));
      end else begin
        check("sweep_lead_valid", 64'(dut_if.out_valid), 64'd0);
      end
      next_cycle();
    end
    next_cycle();

    // 3. Stall with out_ready low: two words fill the pipe, the third is refused.
    dut_if.out_ready = 1'b0;
    dut_if.in_valid = 1'b1; dut_if.op = 3'd0; dut_if.a = 8'hF0; dut_if.b = 8'h3C;
    @(negedge clk); check("stall_acc1", 64'(dut_if.in_ready), 64'd1); next_cycle();
    dut_if.op = 3'd1; dut_if.a = 8'hF0; dut_if.b = 8'h0C;
    @(negedge clk); check("stall_acc2", 64'(dut_if.in_ready), 64'd1); next_cycle();
    dut_if.op = 3'd5; dut_if.a = 8'hAA; dut_if.b = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(dut_if.in_ready), 64'd0);
      check("stall_hold", 64'({dut_if.out_valid, dut_out()}), 64'({1'b1, model(3'd0, 8'hF0, 8'h3C)}));
      next_cycle();
    end
    dut_if.out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 64'(dut_if.in_ready), 64'd1);
    check("release_w1", 64'({dut_if.out_valid, dut_out()}), 64'({1'b1, 8'h30, 1'b0, 1'b0, 1'b0}));
    next_cycle();
    dut_if.in_valid = 1'b0;
    @(negedge clk);
    check("release_w2", 64'({dut_if.out_valid, dut_out()}), 64'({1'b1, 8'hFC, 1'b0, 1'b0, 1'b0}));
    next_cycle();
    @(negedge clk);
    check("release_w3", 64'({dut_if.out_valid, dut_out()}), 64'({1'b1, 8'h55, 1'b0, 1'b0, 1'b0}));
    next_cycle();
    @(negedge clk);
    check("release_empty", 64'(dut_if.out_valid), 64'd0);
    next_cycle();

    // 4. 100 random words under random back-pressure.
    exp_q.delete(); got_q.delete(); mon_en = 1'b1;
    for (int n = 0; n < 100; n++)
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b1);
    drain();
    mon_en = 1'b0;
    check("rand_count", 64'(got_q.size()), 64'd100);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("rand_word_%0d", i), 64'(got_q[i]), 64'(exp_q[i]));

    // 5. Reset with both stages full and out_ready low.
    exp_q.delete(); got_q.delete();
    dut_if.out_ready = 1'b0;
    send(3'd1, 8'h11, 8'h22, 1'b0);
    send(3'd5, 8'h3C, 8'h0F, 1'b0);
    @(negedge clk);
    check("full_in_ready", 64'(dut_if.in_ready), 64'd0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_out_valid", 64'(dut_if.out_valid), 64'd0);
    check("mrst_in_ready", 64'(dut_if.in_ready), 64'd1);
    check("mrst_flags", 64'(dut_out()), 64'({8'h00, 1'b1, 1'b0, 1'b0}));
    next_cycle();
    exp_q.delete(); got_q.delete(); mon_en = 1'b1;
    dut_if.out_ready = 1'b1;
    send(3'd3, 8'h0F, 8'hFF, 1'b0);
    drain();
    mon_en = 1'b0;
    check("post_rst_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0)
      check("post_rst_word", 64'(got_q[0]), 64'({8'hF0, 1'b0, 1'b0, 1'b0}));

    // 6. WIDTH=1 XOR and WIDTH=64 NOT corners.
    w1_if.in_valid = 1'b1;  w1_if.op = 3'd5;  w1_if.a = 1'b1; w1_if.b = 1'b0;
    w64_if.in_valid = 1'b1; w64_if.op = 3'd2; w64_if.a = '0;  w64_if.b = '1;
    next_cycle();
    w1_if.in_valid = 1'b0;
    w64_if.in_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    check("w1_out", 64'({w1_if.out_valid, w1_if.y, w1_if.zero, w1_if.ones, w1_if.parity}),
          64'(5'b1_1_0_1_1));
    check("w64_y", w64_if.y, 64'hFFFF_FFFF_FFFF_FFFF);
    check("w64_flags", 64'({w64_if.out_valid, w64_if.zero, w64_if.ones, w64_if.parity}),
          64'(4'b1_0_1_0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, pipelined bitwise logic unit. It applies one of eight two-operand gate functions across a WIDTH-bit word under an opcode. Results leave through a two-stage valid/ready pipeline with registered reduction flags. It replaces the single-bit gate modules in datapaths that need wide, back-pressured logic operations.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..64)

Ports:
clk  input  1  rising-edge clock; the only clock in the block
rst  input  1  reset, synchronous, active-high
in_valid  input  1  upstream presents op/a/b
in_ready  output  1  block accepts this cycle
op  input  3  operation select (see Behaviour)
a  input  WIDTH  operand A
b  input  WIDTH  operand B (ignored for NOT and PASS_A)
out_valid  output  1  y and flags valid
out_ready  input  1  downstream accepts
y  output  WIDTH  result word
zero  output  1  y == 0
ones  output  1  y == all ones
parity  output  1  XOR-reduction of y

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Op encoding: 0 AND, 1 OR, 2 NOT (~a), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS_A (a). All are bitwise across WIDTH with no carries. Result width is exactly WIDTH.
- Stage 1 (s1): on an input handshake (in_valid & in_ready), register y1 = f(op,a,b) and set s1_valid.
- Stage 2 (s2): on s1 advance, register y = y1, zero = ~|y1, ones = &y1, parity = ^y1, and set out_valid.
- Advance rules:
  - s2_load = s1_valid & (~out_valid | out_ready)
  - in_ready = ~s1_valid | s2_load (combinational, no dependency on in_valid)
  - A handshake is (valid & ready) in the same cycle.
- Latency: an input accepted at edge N appears with out_valid=1 after edge N+1 when out_ready is high. Throughput is 1 word/cycle when out_ready stays high.
- Back-pressure: with out_ready low and both stages full, in_ready=0. y and flags hold stable while out_valid=1 and out_ready=0.
- No loss, no duplication: every accepted input produces exactly one output, in order.
- Simultaneous events: an output handshake and a s1→s2 transfer in the same cycle load s2 with the new word. Concurrent input acceptance refills s1 in the same edge.
- Empty: out_valid=0. y and flags hold their last value and are don't-care to consumers.
- Reset:
  - While rst=1 at an edge: s1_valid=0, out_valid=0, y=0, zero=1, ones=0, parity=0, internal y1=0.
  - in_ready reads 1 during and after reset, because it is derived from s1_valid=0.
  - Reset mid-operation discards both stages. Words accepted before the reset edge are dropped.
- Inputs sampled when in_valid=0 have no effect. An undefined op value cannot occur because all 8 codes are defined.
- WIDTH=1: ones == ~zero, and parity == y.

Decomposition:
- Package logic_unit_pkg: op localparams or enum (OP_AND=3'd0 … OP_PASS_A=3'd7) and the op width constant 3.
- Sub-module logic_op_core: purely combinational, parameter WIDTH, ports op, a, b, y. It is instantiated once in s1 and is also reusable in benches as the reference model.
- Pipeline registers and handshake logic live in logic_unit_pipe.

Test Plan (WIDTH=8 unless noted):
1. Reset with rst=1 for 2 cycles, then release -> out_valid=0, y=8'h00, zero=1, ones=0, parity=0, in_ready=1.
2. Sweep all ops with a=8'hC5, b=8'h3A, out_ready=1, back-to-back -> y sequence 00, FF, 3A, FF, 00, FF, 00, C5, each 2 cycles after acceptance. Flags follow each word, e.g. AND gives zero=1, OR gives ones=1, PASS_A gives parity=0.
3. Stall: hold out_ready=0 and offer 3 words -> first 2 accepted, in_ready=0 on the third. Output stays stable on word 1. Raise out_ready -> words 1, 2, 3 emerge on consecutive cycles, in order, no loss or duplication.
4. Full-rate streaming of 100 random words with random out_ready (50%) -> scoreboard against logic_op_core shows zero mismatches and count 100.
5. Reset mid-stream, with both stages full and out_ready=0, assert rst for 1 cycle -> out_valid=0 the next cycle and no pre-reset word ever appears. A new word accepted after reset emerges correctly.
6. WIDTH=1 instance, op=XOR, a=1, b=0 -> y=1, zero=0, ones=1, parity=1. WIDTH=64 instance, op=NOT, a=0 -> y=all ones, ones=1, parity=0.
